// File: rtl/debounce_bank.sv
// debounce_bank: per-channel input synchroniser, hysteresis debouncer, edge pulses
// and long-press / auto-repeat detection; channels share only clock, reset and tick.
module debounce_bank #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_COUNT    = 16,
  parameter int HOLD_COUNT   = 1000,
  parameter int REPEAT_COUNT = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] edj,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held
);

  localparam int CW   = $clog2(MAX_COUNT);
  localparam int HMAX = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
  localparam int HW   = $clog2(HMAX);

  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNT - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_COUNT > 0) ? REPEAT_COUNT - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_COUNT != 0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [HW-1:0]          hcnt;
    logic                   rep;
    logic                   level;
    logic                   s;
    logic                   commit;
    logic                   edj_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   held_q;

    assign s      = sync[SYNC_STAGES-1];
    assign commit = (s != level) && tick && (cnt == CNT_LAST);

    assign out[i]  = level;
    assign edj[i]  = edj_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
    assign held[i] = held_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], in[i]};
      end
    end

    // Any cycle where the synchronised input agrees with the output restarts qualification.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        level  <= 1'b0;
        edj_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        edj_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s == level) begin
          cnt <= '0;
        end else if (tick) begin
          if (cnt == CNT_LAST) begin
            level  <= s;
            cnt    <= '0;
            edj_q  <= 1'b1;
            rise_q <= s;
            fall_q <= ~s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end

    // A fall commit clears the hold state first, so held never coincides with fall.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hcnt   <= '0;
        rep    <= 1'b0;
        held_q <= 1'b0;
      end else begin
        held_q <= 1'b0;
        if (!level || commit) begin
          hcnt <= '0;
          rep  <= 1'b0;
        end else if (tick) begin
          if (!rep) begin
            if (hcnt == HOLD_LAST) begin
              held_q <= 1'b1;
              hcnt   <= '0;
              rep    <= 1'b1;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end else if (REPEAT_EN) begin
            if (hcnt == REP_LAST) begin
              held_q <= 1'b1;
              hcnt   <= '0;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus queues expected pulse events with the
// edge number they become visible after; a negedge monitor pops and compares them.
module tb_debounce_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b1;
  logic [3:0] in    = 4'b0;
  logic [3:0] out, edj, rise, fall, held;
  logic [3:0] d2_out, d2_edj, d2_rise, d2_fall, d2_held;

  int compared   = 0;
  int mismatched = 0;
  int edge_no    = 0;

  int       d2_held_cnt  = 0;
  int       d2_held_edge = 0;
  logic [3:0] d2_held_bits = 4'b0;

  typedef struct {
    string      name;
    int         at_edge;
    logic [3:0] edj;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] held;
  } ev_t;

  ev_t sb[$];

  debounce_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .MAX_COUNT(4), .HOLD_COUNT(10), .REPEAT_COUNT(3)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .in(in),
    .out(out), .edj(edj), .rise(rise), .fall(fall), .held(held)
  );

  debounce_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .MAX_COUNT(4), .HOLD_COUNT(10), .REPEAT_COUNT(0)
  ) dut_norep (
    .clock(clock), .reset(reset), .tick(tick), .in(in),
    .out(d2_out), .edj(d2_edj), .rise(d2_rise), .fall(d2_fall), .held(d2_held)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_no++;

  // Monitor: every visible pulse must match the head of the scoreboard; overdue entries fail.
  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      while (sb.size() > 0 && sb[0].at_edge < edge_no) begin
        e = sb.pop_front();
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: no pulse seen by edge %0d, required at edge %0d", e.name, edge_no, e.at_edge);
      end
      if (|{edj, rise, fall, held}) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_pulse: edge %0d edj=%b rise=%b fall=%b held=%b, required none",
                   edge_no, edj, rise, fall, held);
        end else begin
          e = sb.pop_front();
          if (e.at_edge != edge_no || e.edj != edj || e.rise != rise || e.fall != fall || e.held != held) begin
            mismatched++;
            $display("[TB] FAIL %s: got edge %0d edj=%b rise=%b fall=%b held=%b, required edge %0d edj=%b rise=%b fall=%b held=%b",
                     e.name, edge_no, edj, rise, fall, held, e.at_edge, e.edj, e.rise, e.fall, e.held);
          end
        end
      end
      if (|d2_held) begin
        d2_held_cnt++;
        d2_held_edge = edge_no;
        d2_held_bits = d2_held;
      end
    end
  end

  task automatic expect_ev(input string name, input int at_edge, input logic [3:0] e_edj,
                           input logic [3:0] e_rise, input logic [3:0] e_fall, input logic [3:0] e_held);
    ev_t e;
    e.name = name; e.at_edge = at_edge;
    e.edj = e_edj; e.rise = e_rise; e.fall = e_fall; e.held = e_held;
    sb.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [3:0] exp_out);
    compared++;
    if ({out, edj, rise, fall, held} !== {exp_out, 16'h0}) begin
      mismatched++;
      $display("[TB] FAIL %s: out=%b edj=%b rise=%b fall=%b held=%b, required out=%b and no pulses",
               name, out, edj, rise, fall, held, exp_out);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive `mask` high for `width` cycles starting at the next posedge, then low.
  task automatic apply_stimulus(input logic [3:0] mask, input int width);
    in = in | mask;
    wait_edges(width);
    in = in & ~mask;
  endtask

  initial begin
    int t0;
    int t1;

    wait_edges(3);
    check_output("reset_state", 4'b0000);
    reset = 1'b0;
    wait_edges(2);

    // Clean press on channel 0, held 8 cycles
    t0 = edge_no;
    expect_ev("clean_rise", t0 + 6,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
    expect_ev("clean_fall", t0 + 14, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    in[0] = 1'b1;
    wait_edges(5);
    check_output("clean_not_yet", 4'b0000);
    wait_edges(2);
    check_output("clean_level", 4'b0001);
    wait_edges(1);
    in[0] = 1'b0;
    wait_edges(10);
    check_output("clean_released", 4'b0000);

    // 3-cycle glitch must be rejected, 4-cycle pulse accepted
    apply_stimulus(4'b0010, 3);
    wait_edges(10);
    check_output("glitch_rejected", 4'b0000);
    t0 = edge_no;
    expect_ev("min_pulse_rise", t0 + 6,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
    expect_ev("min_pulse_fall", t0 + 10, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    apply_stimulus(4'b0010, 4);
    wait_edges(10);
    check_output("min_pulse_done", 4'b0000);

    // Long press on channel 2: held at +16, then every 3, none on the fall edge (+46)
    d2_held_cnt = 0;
    t0 = edge_no;
    expect_ev("long_rise", t0 + 6, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++)
      expect_ev($sformatf("long_held_%0d", k), t0 + 16 + 3 * k, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    expect_ev("long_fall", t0 + 46, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    apply_stimulus(4'b0100, 40);
    wait_edges(12);
    check_output("long_released", 4'b0000);
    check_int("norep_held_count", d2_held_cnt, 1);
    check_int("norep_held_edge", d2_held_edge - t0, 16);
    check_int("norep_held_chan", int'(d2_held_bits), 4);

    // Tick one cycle in four on channel 3, with a one-cycle bounce after two ticks
    t0 = edge_no;
    expect_ev("tick_rise", t0 + 24, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    expect_ev("tick_fall", t0 + 44, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    for (int k = 1; k <= 48; k++) begin
      tick  = (k % 4 == 0);
      in[3] = (k != 9) && (k < 29);
      @(negedge clock);
    end
    tick = 1'b1;
    wait_edges(2);
    check_output("tick_done", 4'b0000);

    // Simultaneous press on channels 0 and 3
    t0 = edge_no;
    expect_ev("simul_rise", t0 + 6,  4'b1001, 4'b1001, 4'b0000, 4'b0000);
    expect_ev("simul_fall", t0 + 11, 4'b1001, 4'b0000, 4'b1001, 4'b0000);
    apply_stimulus(4'b1001, 5);
    wait_edges(10);
    check_output("simul_done", 4'b0000);

    // Reset while counting (cnt=2), then a fresh press, then reset with out high
    in[0] = 1'b1;
    wait_edges(4);
    #1 reset = 1'b1;
    #1 check_output("reset_mid_count", 4'b0000);
    wait_edges(2);
    t1 = edge_no;
    expect_ev("after_reset_rise", t1 + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    reset = 1'b0;
    wait_edges(5);
    check_output("after_reset_pending", 4'b0000);
    wait_edges(3);
    check_output("after_reset_level", 4'b0001);
    #1 reset = 1'b1;
    #1 check_output("reset_out_high", 4'b0000);
    wait_edges(2);
    in[0] = 1'b0;
    reset = 1'b0;
    wait_edges(10);
    check_output("final_idle", 4'b0000);

    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: pulse never seen, required at edge %0d", e.name, e.at_edge);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
